// File: rtl/diff_scan_unit.sv
// diff_scan_unit
//   Multi-cycle bit-difference unit. It compares operands a and b over WIDTH
//   bits, scanning CHUNK bits of a^b per cycle. It reports one of three
//   results: the lowest differing bit, the highest differing bit, or the
//   number of differing bits. Latency is fixed at NCHUNK cycles from accept to
//   out_valid, whatever the data.
//
// Ports
//   clk        clock; all state updates on the rising edge
//   rst        synchronous reset, active low
//   in_valid   operands and mode are valid
//   in_ready   unit is idle and can accept a transaction
//   a, b       operands (WIDTH bits)
//   mode       00 LOW, 01 HIGH, 10 COUNT, 11 reserved (runs as LOW)
//   out_valid  result, equal and mode_o are valid
//   out_ready  consumer accepts the result
//   result     index or count (RES_W bits); WIDTH when no bit differs in LOW/HIGH
//   equal      a == b for the completed transaction
//   mode_o     mode of the completed transaction (reserved reported as 00)
//   busy       a transaction is scanning or waiting for its output handshake
module diff_scan_unit #(
   parameter  int WIDTH  = 32,
   parameter  int CHUNK  = 8,
   localparam int NCHUNK = WIDTH / CHUNK,
   localparam int RES_W  = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [RES_W-1:0] result,
   output logic             equal,
   output logic [1:0]       mode_o,
   output logic             busy
);

   localparam int KW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SCAN,
      S_DONE
   } state_t;

   typedef enum logic [1:0] {
      M_LOW   = 2'b00,
      M_HIGH  = 2'b01,
      M_COUNT = 2'b10
   } mode_t;

   state_t             state;
   state_t             state_nxt;
   logic [KW-1:0]      k;
   logic [WIDTH-1:0]   x;
   mode_t              mode_q;
   logic [RES_W-1:0]   acc;
   logic               found;

   // Per-chunk scan results
   int unsigned        bit_base;
   logic [CHUNK-1:0]   chunk;
   logic               chunk_nz;
   logic               lo_seen;
   logic [RES_W-1:0]   base_r;
   logic [RES_W-1:0]   lo_off;
   logic [RES_W-1:0]   hi_off;
   logic [RES_W-1:0]   pc;
   logic [RES_W-1:0]   acc_nxt;
   logic               found_nxt;
   logic               last;
   logic [RES_W-1:0]   final_res;

   // Chunk extraction and reductions
   always_comb begin
      bit_base = 32'(CHUNK) * 32'(k);
      // A shift keeps the chunk select free of index-width concerns.
      chunk    = CHUNK'(x >> bit_base);
      chunk_nz = |chunk;
      base_r   = RES_W'(bit_base);
      lo_off   = '0;
      hi_off   = '0;
      pc       = '0;
      lo_seen  = 1'b0;
      for (int unsigned i = 0; i < 32'(CHUNK); i++) begin
         if (chunk[i]) begin
            if (!lo_seen) begin
               lo_off  = RES_W'(i);
               lo_seen = 1'b1;
            end
            hi_off = RES_W'(i);
            pc     = pc + RES_W'(1);
         end
      end
   end

   // Accumulator update for the chunk being scanned this cycle
   always_comb begin
      acc_nxt   = acc;
      found_nxt = found;
      case (mode_q)
         M_LOW: begin
            // First nonzero chunk wins; later chunks leave acc alone.
            if (!found && chunk_nz) begin
               acc_nxt   = base_r + lo_off;
               found_nxt = 1'b1;
            end
         end
         M_HIGH: begin
            // Last nonzero chunk wins.
            if (chunk_nz) begin
               acc_nxt   = base_r + hi_off;
               found_nxt = 1'b1;
            end
         end
         M_COUNT: begin
            acc_nxt = acc + pc;
         end
         default: begin
         end
      endcase
      last      = (k == KW'(NCHUNK - 1));
      final_res = ((mode_q == M_COUNT) || found_nxt) ? acc_nxt : RES_W'(WIDTH);
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and handshake outputs
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_nxt = S_SCAN;
            end
         end
         S_SCAN: begin
            busy = 1'b1;
            if (last) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) begin
               state_nxt = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         k      <= '0;
         x      <= '0;
         found  <= 1'b0;
         acc    <= '0;
         mode_q <= M_LOW;
         result <= '0;
         equal  <= 1'b0;
         mode_o <= 2'b00;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  x      <= a ^ b;
                  mode_q <= (mode == 2'b11) ? M_LOW : mode_t'(mode);
                  acc    <= '0;
                  found  <= 1'b0;
                  k      <= '0;
               end
            end
            S_SCAN: begin
               acc   <= acc_nxt;
               found <= found_nxt;
               if (last) begin
                  k      <= '0;
                  result <= final_res;
                  equal  <= (x == '0);
                  mode_o <= mode_q;
               end else begin
                  k <= k + KW'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_diff_scan_unit.sv
// tb_diff_scan_unit
//   Directed bench for diff_scan_unit (WIDTH=32, CHUNK=8). Expected results
//   come from a bit-serial reference model and go through a scoreboard queue.
module tb_diff_scan_unit;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic [1:0]  mode;
   logic        out_valid;
   logic        out_ready;
   logic [5:0]  result;
   logic        equal;
   logic [1:0]  mode_o;
   logic        busy;

   typedef struct packed {
      logic [5:0] res;
      logic       eq;
      logic [1:0] md;
   } exp_t;

   exp_t  sb[$];
   int    checks   = 0;
   int    failures = 0;
   int    cyc      = 0;
   int    accept_cyc = 0;
   string tname    = "init";

   diff_scan_unit #(
      .WIDTH(32),
      .CHUNK(8)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a        (a),
      .b        (b),
      .mode     (mode),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .result   (result),
      .equal    (equal),
      .mode_o   (mode_o),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference: scans all 32 bits one at a time.
   function automatic exp_t model(input logic [31:0] av, input logic [31:0] bv,
                                  input logic [1:0] mv);
      exp_t        e;
      logic [31:0] xv;
      logic [5:0]  lo;
      logic [5:0]  hi;
      logic [5:0]  cnt;
      xv  = av ^ bv;
      lo  = 6'd32;
      hi  = 6'd32;
      cnt = 6'd0;
      for (int i = 0; i < 32; i++) begin
         if (xv[i]) begin
            if (lo == 6'd32) lo = 6'(i);
            hi  = 6'(i);
            cnt = cnt + 6'd1;
         end
      end
      e.md  = (mv == 2'b11) ? 2'b00 : mv;
      e.eq  = (xv == 32'd0);
      e.res = (e.md == 2'b10) ? cnt : (e.md == 2'b01) ? hi : lo;
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s/%s observed=0x%0h expected=0x%0h", tname, tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] av, input logic [31:0] bv,
                       input logic [1:0] mv, input bit push);
      int n;
      n = 0;
      while (!in_ready && n < 20) begin
         step();
         n++;
      end
      chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
      a        = av;
      b        = bv;
      mode     = mv;
      in_valid = 1'b1;
      step();
      accept_cyc = cyc;
      in_valid   = 1'b0;
      // Operands changing after acceptance must have no effect.
      a    = $urandom;
      b    = $urandom;
      mode = 2'($urandom_range(0, 3));
      if (push) sb.push_back(model(av, bv, mv));
   endtask

   task automatic wait_out(output exp_t e);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (!out_valid && n < 20);
      chk("latency", n, 32'd4);
      e = (sb.size() > 0) ? sb.pop_front() : '0;
      chk("result", {26'd0, result}, {26'd0, e.res});
      chk("equal",  {31'd0, equal},  {31'd0, e.eq});
      chk("mode_o", {30'd0, mode_o}, {30'd0, e.md});
   endtask

   task automatic recv();
      exp_t e;
      wait_out(e);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("out_valid_drop", {31'd0, out_valid}, 32'd0);
      chk("in_ready_after", {31'd0, in_ready}, 32'd1);
   endtask

   initial begin
      exp_t e;
      int   prev;
      rst       = 1'b0;
      in_valid  = 1'b1;
      a         = 32'h0000_0001;
      b         = 32'h0;
      mode      = 2'b00;
      out_ready = 1'b0;

      // Reset, with in_valid held high to show it is ignored
      tname = "reset";
      step();
      step();
      chk("out_valid", {31'd0, out_valid}, 32'd0);
      chk("in_ready",  {31'd0, in_ready},  32'd1);
      chk("busy",      {31'd0, busy},      32'd0);
      chk("result",    {26'd0, result},    32'd0);
      chk("equal",     {31'd0, equal},     32'd0);
      chk("mode_o",    {30'd0, mode_o},    32'd0);
      in_valid = 1'b0;
      rst      = 1'b1;
      step();
      chk("busy_after", {31'd0, busy}, 32'd0);

      tname = "low_bit4";
      send(32'h0000_0010, 32'h0, 2'b00, 1'b1);
      recv();

      tname = "equal_b2b";
      send(32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'b00, 1'b1);
      recv();
      prev = accept_cyc;
      send(32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'b01, 1'b1);
      chk("spacing1", accept_cyc - prev, 32'd6);
      recv();
      prev = accept_cyc;
      send(32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'b10, 1'b1);
      chk("spacing2", accept_cyc - prev, 32'd6);
      recv();

      tname = "ends";
      send(32'h8000_0001, 32'h0, 2'b00, 1'b1); recv();
      send(32'h8000_0001, 32'h0, 2'b01, 1'b1); recv();
      send(32'h8000_0001, 32'h0, 2'b10, 1'b1); recv();
      send(32'h8000_0001, 32'h0, 2'b11, 1'b1); recv();

      tname = "all_ones";
      send(32'hFFFF_FFFF, 32'h0, 2'b10, 1'b1); recv();
      send(32'hFFFF_FFFF, 32'h0, 2'b01, 1'b1); recv();

      tname = "mid_chunk";
      send(32'h0012_3400, 32'h0010_0400, 2'b00, 1'b1); recv();
      send(32'h0012_3400, 32'h0010_0400, 2'b01, 1'b1); recv();
      send(32'h0012_3400, 32'h0010_0400, 2'b10, 1'b1); recv();

      tname = "random";
      for (int i = 0; i < 6; i++) begin
         send($urandom, $urandom, 2'($urandom_range(0, 3)), 1'b1);
         recv();
      end

      // Backpressure: hold out_ready low and poke in_valid while DONE
      tname = "backpressure";
      send(32'h00F0_0000, 32'h0, 2'b01, 1'b1);
      wait_out(e);
      for (int i = 0; i < 5; i++) begin
         if (i == 2) begin
            a        = 32'h0000_0001;
            b        = 32'h0;
            mode     = 2'b10;
            in_valid = 1'b1;
         end
         step();
         in_valid = 1'b0;
         chk("hold_valid",  {31'd0, out_valid}, 32'd1);
         chk("hold_result", {26'd0, result},    {26'd0, e.res});
         chk("hold_equal",  {31'd0, equal},     {31'd0, e.eq});
         chk("hold_busy",   {31'd0, busy},      32'd1);
         chk("hold_ready",  {31'd0, in_ready},  32'd0);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("release_valid", {31'd0, out_valid}, 32'd0);
      chk("release_ready", {31'd0, in_ready},  32'd1);
      chk("kept_result",   {26'd0, result},    {26'd0, e.res});
      for (int i = 0; i < 6; i++) begin
         step();
         chk("not_queued", {30'd0, out_valid, busy}, 32'd0);
      end

      // Reset during the second SCAN cycle
      tname = "reset_mid";
      send(32'h0000_0003, 32'h0, 2'b10, 1'b0);
      step();
      rst = 1'b0;
      step();
      chk("out_valid", {31'd0, out_valid}, 32'd0);
      chk("result",    {26'd0, result},    32'd0);
      chk("busy",      {31'd0, busy},      32'd0);
      chk("in_ready",  {31'd0, in_ready},  32'd1);
      rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("no_output", {31'd0, out_valid}, 32'd0);
      end
      send(32'h0000_0100, 32'h0, 2'b00, 1'b1);
      recv();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/diff_scan_unit.md
Name: diff_scan_unit

Overview:
- Multi-cycle, parametrised bit-difference unit for the RISC datapath. Successor to the single-shot combinational diff operation.
- Compares operands A and B over WIDTH bits, CHUNK bits per cycle.
- Returns one of three results, selected by mode: lowest differing bit index, highest differing bit index, or count of differing bits.
- Uses valid/ready handshakes on input and output, so the execute stage can stall around it.

Parameters:
- WIDTH, 32: operand width in bits; must be a multiple of CHUNK.
- CHUNK, 8: bits examined per SCAN cycle; must be at least 1.
- NCHUNK, WIDTH/CHUNK: derived; number of SCAN cycles.
- RES_W, $clog2(WIDTH+1): derived; result width, wide enough to hold the value WIDTH.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-low.
- in_valid  input  1  operands and mode are valid.
- in_ready  output  1  unit can accept a transaction.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- mode  input  2  00 = LOW, 01 = HIGH, 10 = COUNT, 11 = reserved (executes as LOW).
- out_valid  output  1  result, equal and mode_o are valid.
- out_ready  input  1  consumer accepts the result.
- result  output  RES_W  index or count.
- equal  output  1  a == b for the completed transaction.
- mode_o  output  2  mode of the completed transaction, with reserved mapped to 00.
- busy  output  1  state is SCAN or DONE.

Behaviour:
- States: IDLE, SCAN, DONE. Registered state, chunk counter k (0..NCHUNK-1), diff vector x, mode register, result accumulator, found flag.
- Reset: rst low at a rising edge forces the following.
  - state = IDLE, k = 0, x = 0, found = 0.
  - out_valid = 0, result = 0, equal = 0, mode_o = 00.
  - Any in-flight transaction is discarded with no output.
- in_ready = (state == IDLE). in_ready is high during reset, but inputs are ignored while rst is low.
- IDLE, edge with in_valid = 1:
  - Latch x = a ^ b and the mode.
  - Clear the accumulator and found, set k = 0.
  - Go to SCAN.
- SCAN, each cycle, processes bits [k*CHUNK +: CHUNK] of x:
  - LOW: if found = 0 and the chunk is nonzero, acc = k*CHUNK + lowest set bit in the chunk, then found = 1. Later chunks do not change acc.
  - HIGH: if the chunk is nonzero, acc = k*CHUNK + highest set bit in the chunk (overwrite; the last nonzero chunk wins). Set found = 1.
  - COUNT: acc = acc + popcount(chunk).
  - k increments each SCAN cycle. On the edge where k == NCHUNK-1 is processed, go to DONE.
- Entering DONE, all on the same edge:
  - out_valid = 1.
  - result = final acc for COUNT. For LOW/HIGH, result = final acc if found = 1, else WIDTH.
  - equal = (x == 0).
  - mode_o = latched mode.
- Latency is fixed and data-independent: accept at edge E0, out_valid high after edge E0+NCHUNK (4 cycles for the defaults). LOW mode has no early termination.
- DONE:
  - result, equal and mode_o stay stable while out_valid = 1 and out_ready = 0.
  - Edge with out_ready = 1: out_valid = 0, go to IDLE. result, equal and mode_o keep their values until the next DONE.
  - Minimum spacing between accepts is NCHUNK+2 cycles. A new transaction is never accepted in the same cycle as an output handshake.
- Arithmetic:
  - All index and count values are unsigned RES_W bits.
  - COUNT max = WIDTH, which needs RES_W bits; no overflow is possible.
  - The equal-operand sentinel WIDTH matches the existing diff convention (32 when identical).
- Special cases:
  - in_valid asserted while busy: ignored and not queued.
  - a and b may change after acceptance without effect.
  - CHUNK == WIDTH: single-cycle SCAN, latency 1.

Test Plan (WIDTH=32, CHUNK=8):
- a=0x00000010, b=0, mode=LOW -> after 4 cycles: out_valid=1, result=4, equal=0, mode_o=00.
- a=b=0xDEADBEEF, run LOW, HIGH, COUNT back-to-back -> results 32, 32, 0, each with equal=1. Accepts spaced 6 cycles apart.
- a=0x80000001, b=0 -> LOW: 0; HIGH: 31; COUNT: 2. mode=11 gives 0 with mode_o=00.
- a=0xFFFFFFFF, b=0, COUNT -> result=32 (6-bit result, no wrap); HIGH -> 31.
- Backpressure: out_ready held low 5 cycles after out_valid -> result, equal, busy stable; in_ready=0; a pulsed in_valid is ignored. After out_ready=1, in_ready rises next cycle.
- Reset mid-SCAN: rst low at the 2nd SCAN cycle -> next edge out_valid=0, result=0, busy=0, in_ready=1. A fresh a=0x00000100, b=0, LOW returns 8.
